// File: rtl/aes_core_sequencer.sv
// Block-level front end for the 32-bit word-serial AES core: takes one 128-bit block,
// runs clear / 4 loads / operate / 4 reads on the core and returns the 128-bit result.
module aes_core_sequencer #(
  parameter int GAP_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic         mode,
  input  logic [0:127] data_in,
  output logic [0:127] result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         busy,
  output logic [0:31]  core_in,
  output logic [0:5]   core_ctrl,
  input  logic [0:31]  core_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_GAP,
    S_OP,
    S_READ,
    S_DONE
  } state_t;

  localparam logic [0:5] CMD_CLEAR   = 6'd0;
  localparam logic [0:5] CMD_LOAD    = 6'd1;
  localparam logic [0:5] CMD_ENCRYPT = 6'd2;
  localparam logic [0:5] CMD_DECRYPT = 6'd3;
  localparam logic [0:5] CMD_READ    = 6'd4;
  localparam logic [0:5] CMD_IDLE    = 6'd5;

  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);
  localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t       state, state_d;
  state_t       after_gap, after_gap_d;
  state_t       follow;
  logic [1:0]   word_idx, word_idx_d;
  logic [3:0]   gap_cnt, gap_cnt_d;
  logic [0:127] block_q;
  logic         mode_q;
  logic         accept;

  logic         ready_d, busy_d, valid_d;
  logic [0:5]   ctrl_d;
  logic [0:31]  core_in_d;
  logic [0:31]  load_word;

  assign accept = (state == S_IDLE) && start && ready;

  // State, counters, latched block and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      after_gap    <= S_IDLE;
      word_idx     <= '0;
      gap_cnt      <= '0;
      block_q      <= '0;
      mode_q       <= 1'b0;
      ready        <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      core_ctrl    <= CMD_IDLE;
      core_in      <= '0;
    end else begin
      state        <= state_d;
      after_gap    <= after_gap_d;
      word_idx     <= word_idx_d;
      gap_cnt      <= gap_cnt_d;
      ready        <= ready_d;
      busy         <= busy_d;
      result_valid <= valid_d;
      core_ctrl    <= ctrl_d;
      core_in      <= core_in_d;
      if (accept) begin
        block_q <= data_in;
        mode_q  <= mode;
      end
      if (state == S_READ) begin
        case (word_idx)
          2'd0: result[0:31]   <= core_out;
          2'd1: result[32:63]  <= core_out;
          2'd2: result[64:95]  <= core_out;
          2'd3: result[96:127] <= core_out;
        endcase
      end
    end
  end

  // Every command state is followed by a GAP (unless GAP_CYCLES is 0); after_gap
  // remembers where the sequence resumes once the gap expires.
  always_comb begin
    state_d     = state;
    after_gap_d = after_gap;
    word_idx_d  = word_idx;
    gap_cnt_d   = gap_cnt;
    follow      = S_IDLE;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_CLEAR;
          word_idx_d = '0;
        end
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        follow     = (word_idx == 2'd3) ? S_OP : S_LOAD;
        word_idx_d = word_idx + 2'd1;
      end
      S_OP: follow = S_READ;
      S_READ: begin
        follow     = (word_idx == 2'd3) ? S_DONE : S_READ;
        word_idx_d = word_idx + 2'd1;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = after_gap;
        else                     gap_cnt_d = gap_cnt + 4'd1;
      end
      S_DONE: begin
        if (result_valid && result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state == S_LOAD || state == S_OP || state == S_READ) begin
      if (HAS_GAP) begin
        state_d     = S_GAP;
        after_gap_d = follow;
        gap_cnt_d   = '0;
      end else begin
        state_d = follow;
      end
    end
    if (state_d == S_OP && state != S_OP) word_idx_d = '0;
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    ctrl_d    = CMD_IDLE;
    load_word = '0;
    case (word_idx_d)
      2'd0: load_word = block_q[0:31];
      2'd1: load_word = block_q[32:63];
      2'd2: load_word = block_q[64:95];
      2'd3: load_word = block_q[96:127];
    endcase
    core_in_d = (state_d == S_LOAD) ? load_word : core_in;
    case (state_d)
      S_CLEAR: ctrl_d = CMD_CLEAR;
      S_LOAD:  ctrl_d = CMD_LOAD;
      S_OP:    ctrl_d = mode_q ? CMD_DECRYPT : CMD_ENCRYPT;
      S_READ:  ctrl_d = CMD_READ;
      default: ctrl_d = CMD_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Bench for aes_core_sequencer: two instances (GAP_CYCLES 1 and 0) share a behavioural
// word-serial core that knows the FIPS-197 C.1 vector (key 000102..0f).
module tb_aes_core_sequencer;

  localparam logic [127:0] PT   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] JUNK = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;

  logic         clk = 1'b0;
  logic         rst, start, mode, result_ready, sel;
  logic [127:0] data_in;

  logic         ready_g1, valid_g1, busy_g1, ready_g0, valid_g0, busy_g0;
  logic [127:0] result_g1, result_g0;
  logic [31:0]  core_in_g1, core_in_g0;
  logic [5:0]   ctrl_g1, ctrl_g0;

  logic         ready, result_valid, busy;
  logic [127:0] result;
  logic [31:0]  core_in, core_out;
  logic [5:0]   core_ctrl;

  int compared   = 0;
  int mismatched = 0;
  int exp_trace[$];

  always #5 clk = ~clk;

  aes_core_sequencer #(.GAP_CYCLES(1)) u_dut_g1 (
    .clk(clk), .rst(rst), .start(start & sel), .ready(ready_g1), .mode(mode),
    .data_in(data_in), .result(result_g1), .result_valid(valid_g1),
    .result_ready(result_ready & sel), .busy(busy_g1), .core_in(core_in_g1),
    .core_ctrl(ctrl_g1), .core_out(core_out)
  );

  aes_core_sequencer #(.GAP_CYCLES(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .start(start & ~sel), .ready(ready_g0), .mode(mode),
    .data_in(data_in), .result(result_g0), .result_valid(valid_g0),
    .result_ready(result_ready & ~sel), .busy(busy_g0), .core_in(core_in_g0),
    .core_ctrl(ctrl_g0), .core_out(core_out)
  );

  assign ready        = sel ? ready_g1   : ready_g0;
  assign result_valid = sel ? valid_g1   : valid_g0;
  assign busy         = sel ? busy_g1    : busy_g0;
  assign result       = sel ? result_g1  : result_g0;
  assign core_in      = sel ? core_in_g1 : core_in_g0;
  assign core_ctrl    = sel ? ctrl_g1    : ctrl_g0;

  // Behavioural core: only the known vector round-trips, anything else comes back scrambled.
  logic [31:0] core_buf[4];
  logic [31:0] core_res[4];
  logic [1:0]  ld_ptr, rd_ptr;
  logic [127:0] core_blk;

  assign core_blk = {core_buf[0], core_buf[1], core_buf[2], core_buf[3]};
  assign core_out = (core_ctrl == 6'd4) ? core_res[rd_ptr] : 32'h0;

  always @(posedge clk) begin
    case (core_ctrl)
      6'd0: begin ld_ptr <= 2'd0; rd_ptr <= 2'd0; end
      6'd1: begin core_buf[ld_ptr] <= core_in; ld_ptr <= ld_ptr + 2'd1; end
      6'd2, 6'd3: begin
        rd_ptr <= 2'd0;
        if (core_ctrl == 6'd2 && core_blk == PT)
          {core_res[0], core_res[1], core_res[2], core_res[3]} <= CT;
        else if (core_ctrl == 6'd3 && core_blk == CT)
          {core_res[0], core_res[1], core_res[2], core_res[3]} <= PT;
        else
          {core_res[0], core_res[1], core_res[2], core_res[3]} <= core_blk ^ JUNK;
      end
      6'd4: rd_ptr <= rd_ptr + 2'd1;
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic void buildTrace(input int gap, input logic m);
    exp_trace.delete();
    exp_trace.push_back(0);
    for (int w = 0; w < 4; w++) begin
      exp_trace.push_back(1);
      for (int g = 0; g < gap; g++) exp_trace.push_back(5);
    end
    exp_trace.push_back(m ? 3 : 2);
    for (int g = 0; g < gap; g++) exp_trace.push_back(5);
    for (int r = 0; r < 4; r++) begin
      exp_trace.push_back(4);
      for (int g = 0; g < gap; g++) exp_trace.push_back(5);
    end
  endfunction

  // One block from accept to result_valid, recording the command trace.
  task automatic applyStimulus(input logic [127:0] blk, input logic m, input logic [127:0] exp_res, input string tag);
    int cyc;
    int gap;
    int got[$];
    gap = sel ? 1 : 0;
    buildTrace(gap, m);
    checkOutput({tag, " ready before accept"}, 128'(ready), 128'(1));
    data_in = blk;
    mode    = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = ~blk;
    mode    = ~m;
    checkOutput({tag, " busy after accept"}, 128'(busy), 128'(1));
    checkOutput({tag, " ready after accept"}, 128'(ready), 128'(0));
    cyc = 1;
    while (!result_valid && cyc < 100) begin
      got.push_back(int'(core_ctrl));
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, 128'(cyc), 128'(2 + 9 * (1 + gap)));
    checkOutput({tag, " trace length"}, 128'(got.size()), 128'(exp_trace.size()));
    for (int i = 0; i < got.size() && i < exp_trace.size(); i++)
      checkOutput($sformatf("%s ctrl[%0d]", tag, i), 128'(got[i]), 128'(exp_trace[i]));
    checkOutput({tag, " result"}, result, exp_res);
  endtask

  // Hold off the consumer, poke start in the window, then complete the handshake.
  task automatic releaseResult(input int hold, input logic [127:0] exp_res, input string tag);
    for (int i = 0; i < hold; i++) begin
      start = (i == 3);
      @(negedge clk);
      checkOutput($sformatf("%s hold%0d result", tag, i), result, exp_res);
      checkOutput($sformatf("%s hold%0d valid", tag, i), 128'(result_valid), 128'(1));
      checkOutput($sformatf("%s hold%0d ready", tag, i), 128'(ready), 128'(0));
      checkOutput($sformatf("%s hold%0d ctrl", tag, i), 128'(core_ctrl), 128'(5));
    end
    start        = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput({tag, " valid after handshake"}, 128'(result_valid), 128'(0));
    checkOutput({tag, " ready after handshake"}, 128'(ready), 128'(1));
    checkOutput({tag, " busy after handshake"}, 128'(busy), 128'(0));
    checkOutput({tag, " result kept"}, result, exp_res);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; mode = 1'b0; result_ready = 1'b0; data_in = '0; sel = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset ready", 128'(ready), 128'(1));
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset valid", 128'(result_valid), 128'(0));
    checkOutput("reset result", result, 128'(0));
    checkOutput("reset ctrl", 128'(core_ctrl), 128'(5));
    checkOutput("reset core_in", 128'(core_in), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(PT, 1'b0, CT, "enc");
    releaseResult(10, CT, "enc bp");
    applyStimulus(CT, 1'b1, PT, "dec");
    releaseResult(0, PT, "dec");

    // Abort during the second LOAD (cycle 4 after accept).
    data_in = PT; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid ctrl load1", 128'(core_ctrl), 128'(1));
    checkOutput("mid core_in w1", 128'(core_in), 128'(32'h44556677));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid rst ctrl", 128'(core_ctrl), 128'(5));
    checkOutput("mid rst busy", 128'(busy), 128'(0));
    checkOutput("mid rst ready", 128'(ready), 128'(1));
    checkOutput("mid rst valid", 128'(result_valid), 128'(0));
    checkOutput("mid rst result", result, 128'(0));
    repeat (3) @(negedge clk);
    checkOutput("mid rst quiet ctrl", 128'(core_ctrl), 128'(5));
    applyStimulus(PT, 1'b0, CT, "post rst");
    releaseResult(0, CT, "post rst");

    sel = 1'b0;
    @(negedge clk);
    applyStimulus(PT, 1'b0, CT, "gap0");
    releaseResult(2, CT, "gap0");

    // Back-to-back: start and result_ready both held high.
    sel = 1'b1;
    @(negedge clk);
    data_in = PT; mode = 1'b0; start = 1'b1; result_ready = 1'b1;
    @(negedge clk);
    data_in = CT; mode = 1'b1;
    cyc = 1;
    while (!result_valid && cyc < 100) begin @(negedge clk); cyc++; end
    checkOutput("b2b first latency", 128'(cyc), 128'(20));
    checkOutput("b2b first result", result, CT);
    @(negedge clk);
    checkOutput("b2b gap valid", 128'(result_valid), 128'(0));
    checkOutput("b2b gap ready", 128'(ready), 128'(1));
    checkOutput("b2b gap ctrl", 128'(core_ctrl), 128'(5));
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b second busy", 128'(busy), 128'(1));
    checkOutput("b2b second ctrl", 128'(core_ctrl), 128'(0));
    cyc = 1;
    while (!result_valid && cyc < 100) begin @(negedge clk); cyc++; end
    checkOutput("b2b second latency", 128'(cyc), 128'(20));
    checkOutput("b2b second result", result, PT);
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput("b2b end ready", 128'(ready), 128'(1));
    checkOutput("b2b end valid", 128'(result_valid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aes_core_sequencer.md
Name: aes_core_sequencer

Overview:
Drives the 32-bit word-serial AES core (32-bit data in, 6-bit control, 32-bit data out) from a 128-bit block-level valid/ready interface. It accepts one 128-bit block plus an encrypt/decrypt mode. It then issues the fixed core command sequence: clear, 4 word loads, operate, and 4 word reads. The result is returned as one 128-bit word. It sits between the system datapath and the AES core, so no other logic toggles core control codes.

Parameters:
GAP_CYCLES, 1, number of cycles the idle/commit code (5) is held after every load, operate and read command; legal range 0..15.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  block request valid
ready  out  1  sequencer can accept a block (high only in IDLE)
mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept
data_in  in  128  [0:127] block; word0 = [0:31] … word3 = [96:127]
result  out  128  [0:127] processed block, same word order
result_valid  out  1  result holds a complete block
result_ready  in  1  consumer accepts result
busy  out  1  high from accept until result handshake completes
core_in  out  32  [0:31] word to core
core_ctrl  out  6  [0:5] core command: 0 clear, 1 load, 2 encrypt, 3 decrypt, 4 read, 5 idle/commit
core_out  in  32  [0:31] word from core

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE, ready = 1, busy = 0, result_valid = 0, result = 0.
  - core_ctrl = 5, core_in = 0.
  - Reset mid-sequence aborts immediately; no further commands are issued.
- Accept: start & ready at an edge latches data_in and mode, and moves to CLEAR. start while not ready is ignored; no queuing.
- States and command codes:
  - IDLE: core_ctrl = 5.
  - CLEAR (1 cycle): core_ctrl = 0.
  - LOAD (1 cycle): core_ctrl = 1, core_in = latched word[i].
  - GAP (GAP_CYCLES cycles): core_ctrl = 5; core_in holds its last value.
  - OP (1 cycle): core_ctrl = 2 if mode = 0, 3 if mode = 1.
  - READ (1 cycle): core_ctrl = 4; core_out is captured into result word[j] at the edge ending READ.
  - DONE: result_valid = 1, core_ctrl = 5.
- Sequence order: CLEAR; then (LOAD w0, GAP) … (LOAD w3, GAP); then (OP, GAP); then (READ r0, GAP) … (READ r3, GAP); then DONE.
- A 2-bit word index counts LOAD and READ; it is cleared on entry to CLEAR and on entry to the OP phase.
- A 4-bit gap counter is used; if GAP_CYCLES = 0, the GAP states are skipped entirely.
- Latency: result_valid rises 2 + 9·(1+GAP_CYCLES) cycles after the accept edge. That is 20 for GAP_CYCLES = 1 and 11 for 0.
- DONE handshake:
  - result_valid & result_ready at an edge returns to IDLE; result_valid drops and ready rises on the next cycle.
  - result stays stable while result_valid is high.
  - result keeps its value after the handshake until the next capture.
- Back-pressure: the sequencer holds in DONE indefinitely; core_ctrl stays 5.
- Changes to data_in or mode after accept have no effect on the block in flight.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Encrypt, GAP = 1:
  - Stimulus: core loaded with key 000102…0f; data_in = 00112233_44556677_8899aabb_ccddeeff, mode = 0.
  - Response: core_ctrl trace 0,1,5,1,5,1,5,1,5,2,5,4,5,4,5,4,5,4,5; result_valid at cycle 20; result = 69c4e0d8_6a7b0430_d8cdb780_70b4c55a.
- Decrypt:
  - Stimulus: data_in = 69c4e0d8_6a7b0430_d8cdb780_70b4c55a, mode = 1.
  - Response: OP cycle core_ctrl = 3; result = 00112233_44556677_8899aabb_ccddeeff.
- Back-pressure:
  - Stimulus: hold result_ready = 0 for 10 cycles after result_valid; pulse start during that window.
  - Response: result stable; start ignored; ready = 0; core_ctrl = 5; after result_ready, ready = 1 one cycle later.
- Reset mid-operation:
  - Stimulus: assert rst during the second LOAD.
  - Response: next cycle core_ctrl = 5, busy = 0, ready = 1, result_valid = 0. A fresh encrypt then yields the correct ciphertext.
- GAP_CYCLES = 0:
  - Stimulus: run the encrypt vector.
  - Response: trace 0,1,1,1,1,2,4,4,4,4; result_valid at cycle 11; same ciphertext.
- Back-to-back blocks:
  - Stimulus: start held high continuously, result_ready held high.
  - Response: second accept on the cycle ready returns; both results correct; no command overlap.
